// File: rtl/vga_scan_compositor.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_compositor
// Description : VGA pixel-scan master. It generates the scan coordinates and
//               composites the sprite over the background onto
//               pipeline-aligned sync/RGB pins.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_compositor #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [9:0]  x,
    output logic [8:0]  y,
    input  logic        sprite_enable,
    input  logic [11:0] sprite_data,
    input  logic [11:0] bg_color,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        pixel_tick,
    output logic        frame_start
);

    localparam int c_div_w = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_first   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_hs_last    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_first   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_vs_last    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [c_div_w-1:0] r_div;
    logic [9:0]         r_h_count;
    logic [9:0]         r_v_count;
    logic               r_hsync;
    logic               r_vsync;
    logic [11:0]        r_rgb;
    logic               r_frame_start;

    logic w_tick;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_hs_n;
    logic w_vs_n;

    assign w_tick   = (r_div == c_div_last);
    assign w_h_wrap = (r_h_count == c_h_last);
    assign w_v_wrap = (r_v_count == c_v_last);

    // Decode of the coordinate currently on x/y; it reaches the pins one pixel later.
    assign w_active = (r_h_count < c_h_vis) && (r_v_count < c_v_vis);
    assign w_hs_n   = !((r_h_count >= c_hs_first) && (r_h_count <= c_hs_last));
    assign w_vs_n   = !((r_v_count >= c_vs_first) && (r_v_count <= c_vs_last));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_h_count <= 10'd0;
                r_v_count <= w_v_wrap ? 10'd0 : r_v_count + 10'd1;
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
        end
    end

    // The sprite answer for the current coordinate has been stable since one CLK
    // after x/y moved, so sampling it on the next tick keeps RGB aligned with sync.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (w_tick) begin
            r_hsync <= w_hs_n;
            r_vsync <= w_vs_n;
            if (!w_active) begin
                r_rgb <= 12'h000;
            end else if (sprite_enable) begin
                r_rgb <= sprite_data;
            end else begin
                r_rgb <= bg_color;
            end
        end
    end

    // High for the single CLK in which the counters read (0,0) after a wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
        end
    end

    assign x           = r_h_count;
    assign y           = r_v_count[8:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign pixel_tick  = w_tick;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_compositor
// Description : Scoreboard bench for vga_scan_compositor on a reduced raster,
//               with a one-CLK-late sprite block and randomized colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_compositor;

    localparam int CD = 3;
    localparam int HV = 20, HF = 3, HS = 5, HB = 4;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sprite_enable = 1'b0;
    logic [11:0] sprite_data = 12'h000;
    logic [11:0] bg_color = 12'h00F;
    logic        hsync, vsync, pixel_tick, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    always #5 CLK = ~CLK;

    vga_scan_compositor #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .CLK(CLK), .RST(RST), .x(x), .y(y),
        .sprite_enable(sprite_enable), .sprite_data(sprite_data), .bg_color(bg_color),
        .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pixel_tick(pixel_tick), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Sprite configuration, changed only at pixel starts.
    int         spr_mode = 0;
    int         spr_x0 = 0, spr_x1 = 0, spr_y0 = 0, spr_y1 = 0;
    logic [11:0] spr_col = 12'hF00;
    bit         spr_lock = 1'b0;

    function automatic bit spr_hit(input int h, input int v);
        case (spr_mode)
            0:       return (h >= spr_x0) && (h <= spr_x1) && (v >= spr_y0) && (v <= spr_y1);
            1:       return 1'b1;
            default: return ((h * 7 + v * 3) % 5) < 2;
        endcase
    endfunction

    // Sprite block: answers one CLK after x/y change.
    always @(posedge CLK) begin
        sprite_enable <= spr_hit(int'(x), int'(y));
        sprite_data   <= spr_col;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    // Expected pins after the tick that advances the scan from pixel index n to n+1.
    function automatic exp_t predict(input int n);
        exp_t e;
        int h, v, hn, vn;
        h  = n % HT;
        v  = (n / HT) % VT;
        hn = (n + 1) % HT;
        vn = ((n + 1) / HT) % VT;
        e.x   = 10'(hn);
        e.y   = 9'(vn);
        e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        e.fs  = ((n + 1) % FT) == 0;
        e.rgb = ((h < HV) && (v < VV)) ? (spr_hit(h, v) ? spr_col : bg_color) : 12'h000;
        return e;
    endfunction

    // ---------------- stimulus + reference model ----------------
    int m_div = 0;
    int m_n   = 0;

    task automatic update_stim();
        if (($urandom % 40) == 0) bg_color = 12'($urandom);
        if (!spr_lock && (m_n % FT) == 0) begin
            spr_mode = (($urandom % 3) == 0) ? 2 : 0;
            spr_x0   = int'($urandom_range(0, HV - 1));
            spr_x1   = spr_x0 + int'($urandom_range(0, 12));
            spr_y0   = int'($urandom_range(0, VV - 1));
            spr_y1   = spr_y0 + int'($urandom_range(0, 8));
            spr_col  = 12'($urandom);
        end
    endtask

    task automatic cycle(input bit rst_next);
        @(posedge CLK);
        #1;
        if (RST) begin
            m_div = 0;
            m_n   = 0;
        end else if (m_div == CD - 1) begin
            m_div = 0;
            m_n++;
        end else begin
            m_div++;
        end
        if (m_div == 0) update_stim();
        RST = rst_next;
        if (!rst_next && m_div == CD - 1) sb.push_back(predict(m_n));
    endtask

    initial begin
        repeat (3) cycle(1'b1);
        repeat (2 * FT * CD + 100) cycle(1'b0);
        // Reset held 5 CLK mid-line.
        for (int i = 0; i < HT * CD && (m_n % HT) != HT / 2; i++) cycle(1'b0);
        spr_lock = 1'b1;
        spr_mode = 1;
        spr_col  = 12'hFFF;
        repeat (5) cycle(1'b1);
        // Sprite asserted over a whole frame; blanking must still win.
        repeat (FT * CD + 2 * CD) cycle(1'b0);
        spr_lock = 1'b0;
        // Reset while vsync is low on its second line.
        for (int i = 0; i < 2 * FT * CD && (m_n % FT) != (VV + VF + 1) * HT + 3; i++) cycle(1'b0);
        cycle(1'b1);
        repeat (FT * CD * 3 / 2) cycle(1'b0);
        for (int i = 0; i < 2 * CD && m_div != 1; i++) cycle(1'b0);
        chk("pending_at_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- monitor ----------------
    exp_t cur;
    exp_t c_reset_exp = '{x: 10'd0, y: 9'd0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 12'h000};
    bit   last_rst = 1'b1;
    bit   last_tick = 1'b0;
    bit   popped;
    bit   first_tick_seen;
    bit   vs_fall_seen;
    logic prev_hs, prev_vs;
    int   cyc = 0;
    int   hs_run = 0;

    initial begin
        cur = c_reset_exp;
        forever begin
            @(negedge CLK);
            popped = 1'b0;
            if (last_rst) begin
                sb.delete();
                cur             = c_reset_exp;
                cyc             = 0;
                hs_run          = 0;
                first_tick_seen = 1'b0;
                vs_fall_seen    = 1'b0;
                prev_hs         = 1'b1;
                prev_vs         = 1'b1;
            end else begin
                cyc++;
                if (last_tick) begin
                    if (sb.size() == 0) begin
                        chk("tick_without_expectation", 1, 0);
                    end else begin
                        cur    = sb.pop_front();
                        popped = 1'b1;
                    end
                end
            end

            chk("x", int'(x), int'(cur.x));
            chk("y", int'(y), int'(cur.y));
            chk("hsync", int'(hsync), int'(cur.hs));
            chk("vsync", int'(vsync), int'(cur.vs));
            chk("rgb", int'({vga_r, vga_g, vga_b}), int'(cur.rgb));
            chk("frame_start", int'(frame_start), int'(popped && cur.fs));
            chk("tick_backlog", int'(sb.size() > 1), 0);

            if (popped) begin
                if (!first_tick_seen) begin
                    chk("first_tick_latency", cyc, CD);
                    first_tick_seen = 1'b1;
                end
                if (hsync == 1'b0) hs_run++;
                if (hsync == 1'b1 && prev_hs == 1'b0) begin
                    chk("hsync_width", hs_run, HS);
                    hs_run = 0;
                end
                if (vsync == 1'b0 && prev_vs == 1'b1 && !vs_fall_seen) begin
                    chk("vsync_after_reset", cyc, ((VV + VF) * HT + 1) * CD);
                    vs_fall_seen = 1'b1;
                end
                prev_hs = hsync;
                prev_vs = vsync;
            end
            if (frame_start == 1'b1) chk("frame_period", cyc % (FT * CD), 0);

            last_rst  = RST;
            last_tick = pixel_tick;
        end
    end

endmodule
`default_nettype wire
